// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the trap controller: state encoding,
// cause codes, default handler vectors and the vector-to-cause decode.
package trap_controller_pkg;

   localparam int ADDR_W = 19;

   localparam logic [ADDR_W-1:0] DEF_DIV0_VEC = 19'h7FFF0;
   localparam logic [ADDR_W-1:0] DEF_OVF_VEC  = 19'h7FFF1;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_DIV0 = 2'b01;
   localparam logic [1:0] CAUSE_OVF  = 2'b10;
   localparam logic [1:0] CAUSE_DBL  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_REDIRECT,
      S_HANDLER,
      S_RETURN,
      S_HALT
   } trap_state_e;

   // Unrecognised vectors are reported as overflow.
   function automatic logic [1:0] decode_cause(input logic [ADDR_W-1:0] vec,
                                               input logic [ADDR_W-1:0] div0_vec,
                                               input logic [ADDR_W-1:0] ovf_vec);
      if (vec == div0_vec)     return CAUSE_DIV0;
      else if (vec == ovf_vec) return CAUSE_OVF;
      else                     return CAUSE_OVF;
   endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Bundle between EX-stage exception detect / fetch and the trap controller.
// Optional TRAP_COUNT_EN adds the trap counter and its clear.
interface trap_controller_if;
   import trap_controller_pkg::*;

   // Pipeline -> controller: single-cycle qualifiers, no backpressure.
   logic              exception;
   logic [ADDR_W-1:0] handler_address;
   logic [ADDR_W-1:0] ex_pc;
   logic              eret;

   // Controller -> pipeline / fetch, all registered.
   logic              flush;
   logic              pc_redirect;
   logic [ADDR_W-1:0] redirect_addr;
   logic [ADDR_W-1:0] epc;
   logic [1:0]        cause;
   logic              in_handler;
   logic              halted;
   trap_state_e       state;

`ifdef TRAP_COUNT_EN
   logic              count_clr;
   logic [15:0]       trap_count;
`endif

   modport master (
      output exception, handler_address, ex_pc, eret,
`ifdef TRAP_COUNT_EN
      output count_clr,
      input  trap_count,
`endif
      input  flush, pc_redirect, redirect_addr, epc, cause, in_handler, halted, state
   );

   modport slave (
      input  exception, handler_address, ex_pc, eret,
`ifdef TRAP_COUNT_EN
      input  count_clr,
      output trap_count,
`endif
      output flush, pc_redirect, redirect_addr, epc, cause, in_handler, halted, state
   );

endinterface

// File: rtl/trap_event_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module trap_event_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + W'(1);
   end

endmodule

// File: rtl/trap_controller.sv
// Trap sequencer: latch PC/cause, flush, redirect to handler, return on eret.
// Optional macro TRAP_COUNT_EN adds a saturating trap counter.
module trap_controller
   import trap_controller_pkg::*;
#(
   parameter int                FLUSH_CYCLES = 2,
   parameter logic [ADDR_W-1:0] DIV0_VEC     = DEF_DIV0_VEC,
   parameter logic [ADDR_W-1:0] OVF_VEC      = DEF_OVF_VEC
) (
   input logic               clk,
   input logic               rst,
   trap_controller_if.slave  bus
);

   trap_state_e       state, state_n;
   logic [2:0]        cnt, cnt_n;
   logic [ADDR_W-1:0] target, target_n;
   logic [ADDR_W-1:0] epc, epc_n;
   logic [ADDR_W-1:0] redirect_addr, redirect_addr_n;
   logic [1:0]        cause, cause_n;
   logic              in_handler, in_handler_n;
   logic              flush, pc_redirect, halted;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         target        <= '0;
         epc           <= '0;
         redirect_addr <= '0;
         cause         <= CAUSE_NONE;
         in_handler    <= 1'b0;
         flush         <= 1'b0;
         pc_redirect   <= 1'b0;
         halted        <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         target        <= target_n;
         epc           <= epc_n;
         redirect_addr <= redirect_addr_n;
         cause         <= cause_n;
         in_handler    <= in_handler_n;
         flush         <= (state_n != S_IDLE) && (state_n != S_HANDLER);
         pc_redirect   <= (state_n == S_REDIRECT) || (state_n == S_RETURN);
         halted        <= (state_n == S_HALT);
      end
   end

   // Register values are computed for the state being entered, so every
   // output is a flop that reflects the current state.
   always_comb begin
      state_n         = state;
      cnt_n           = cnt;
      target_n        = target;
      epc_n           = epc;
      redirect_addr_n = redirect_addr;
      cause_n         = cause;
      in_handler_n    = in_handler;
      case (state)
         S_IDLE: begin
            if (bus.exception) begin
               epc_n    = bus.ex_pc;
               target_n = bus.handler_address;
               cause_n  = decode_cause(bus.handler_address, DIV0_VEC, OVF_VEC);
               cnt_n    = 3'(FLUSH_CYCLES);
               state_n  = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // Inputs here come from squashed instructions and are ignored.
            if (cnt <= 3'd1) begin
               state_n         = S_REDIRECT;
               redirect_addr_n = target;
            end else begin
               cnt_n = cnt - 3'd1;
            end
         end
         S_REDIRECT: begin
            state_n      = S_HANDLER;
            in_handler_n = 1'b1;
         end
         S_HANDLER: begin
            if (bus.exception) begin
               state_n = S_HALT;
               cause_n = CAUSE_DBL;
            end else if (bus.eret) begin
               state_n         = S_RETURN;
               redirect_addr_n = epc + ADDR_W'(1);
            end
         end
         S_RETURN: begin
            state_n      = S_IDLE;
            in_handler_n = 1'b0;
            cause_n      = CAUSE_NONE;
         end
         S_HALT:  state_n = S_HALT;
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.flush         = flush;
   assign bus.pc_redirect   = pc_redirect;
   assign bus.redirect_addr = redirect_addr;
   assign bus.epc           = epc;
   assign bus.cause         = cause;
   assign bus.in_handler    = in_handler;
   assign bus.halted        = halted;
   assign bus.state         = state;

`ifdef TRAP_COUNT_EN
   logic trap_start;
   assign trap_start = (state == S_IDLE) && bus.exception;

   trap_event_counter #(.W(16)) u_trap_event_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (trap_start),
      .clr   (bus.count_clr),
      .count (bus.trap_count)
   );
`endif

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: reset, DIV0 trap, wrap on return,
// ignored inputs during flush, double fault, optional trap counter.
module tb_trap_controller;
   import trap_controller_pkg::*;

   localparam int FC = 2;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   trap_controller_if bus ();

   trap_controller #(.FLUSH_CYCLES(FC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

`ifdef TRAP_COUNT_EN
   logic       sat_inc, sat_clr;
   logic [1:0] sat_count;
   trap_event_counter #(.W(2)) u_sat (
      .clk   (clk),
      .rst   (rst),
      .inc   (sat_inc),
      .clr   (sat_clr),
      .count (sat_count)
   );
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are stable when this returns.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_trap(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] vec);
      bus.ex_pc           = pc;
      bus.handler_address = vec;
      bus.exception       = 1'b1;
      tick();
      bus.exception       = 1'b0;
   endtask

   // From the first FLUSH cycle, step into HANDLER.
   task automatic to_handler();
      for (int i = 0; i < FC + 1; i++) tick();
   endtask

   task automatic do_eret();
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      tick();
   endtask

   initial begin
      rst                 = 1'b1;
      bus.exception       = 1'b1;
      bus.handler_address = DEF_DIV0_VEC;
      bus.ex_pc           = 19'h00055;
      bus.eret            = 1'b0;
`ifdef TRAP_COUNT_EN
      bus.count_clr = 1'b0;
      sat_inc       = 1'b0;
      sat_clr       = 1'b0;
`endif
      tick();
      tick();
      chk("rst_flush",   32'(bus.flush), 0);
      chk("rst_redir",   32'(bus.pc_redirect), 0);
      chk("rst_raddr",   32'(bus.redirect_addr), 0);
      chk("rst_epc",     32'(bus.epc), 0);
      chk("rst_cause",   32'(bus.cause), 0);
      chk("rst_inh",     32'(bus.in_handler), 0);
      chk("rst_halted",  32'(bus.halted), 0);
      chk("rst_state",   32'(bus.state), 32'(S_IDLE));
      rst           = 1'b0;
      bus.exception = 1'b0;
      tick();
      chk("idle_flush", 32'(bus.flush), 0);

      // eret in IDLE does nothing
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      chk("idle_eret_redir", 32'(bus.pc_redirect), 0);
      chk("idle_eret_state", 32'(bus.state), 32'(S_IDLE));

      // divide-by-zero trap
      start_trap(19'h00123, 19'h7FFF0);
      chk("div0_flush1", 32'(bus.flush), 1);
      chk("div0_redir1", 32'(bus.pc_redirect), 0);
      tick();
      chk("div0_flush2", 32'(bus.flush), 1);
      chk("div0_redir2", 32'(bus.pc_redirect), 0);
      tick();
      chk("div0_redir3", 32'(bus.pc_redirect), 1);
      chk("div0_raddr",  32'(bus.redirect_addr), 32'h7FFF0);
      chk("div0_flush3", 32'(bus.flush), 1);
      tick();
      chk("div0_inh",    32'(bus.in_handler), 1);
      chk("div0_epc",    32'(bus.epc), 32'h00123);
      chk("div0_cause",  32'(bus.cause), 1);
      chk("div0_redir4", 32'(bus.pc_redirect), 0);
      chk("div0_flush4", 32'(bus.flush), 0);
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      chk("ret_redir", 32'(bus.pc_redirect), 1);
      chk("ret_raddr", 32'(bus.redirect_addr), 32'h00124);
      chk("ret_flush", 32'(bus.flush), 1);
      tick();
      chk("ret_inh",   32'(bus.in_handler), 0);
      chk("ret_cause", 32'(bus.cause), 0);
      chk("ret_epc",   32'(bus.epc), 32'h00123);
      chk("ret_state", 32'(bus.state), 32'(S_IDLE));

      // unknown vector decodes as OVF; return from 7FFFF wraps to 0
      start_trap(19'h7FFFF, 19'h01234);
      to_handler();
      chk("wrap_cause", 32'(bus.cause), 2);
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      chk("wrap_redir", 32'(bus.pc_redirect), 1);
      chk("wrap_raddr", 32'(bus.redirect_addr), 0);
      chk("wrap_flush", 32'(bus.flush), 1);
      tick();
      chk("wrap_inh",   32'(bus.in_handler), 0);
      chk("wrap_cause0", 32'(bus.cause), 0);

      // second exception and eret during FLUSH are ignored
      start_trap(19'h00200, 19'h7FFF1);
      bus.exception       = 1'b1;
      bus.eret            = 1'b1;
      bus.handler_address = 19'h7FFF0;
      bus.ex_pc           = 19'h00300;
      tick();
      bus.exception = 1'b0;
      bus.eret      = 1'b0;
      tick();
      chk("ovf_redir", 32'(bus.pc_redirect), 1);
      chk("ovf_raddr", 32'(bus.redirect_addr), 32'h7FFF1);
      chk("ovf_cause", 32'(bus.cause), 2);
      chk("ovf_epc",   32'(bus.epc), 32'h00200);
      tick();
      do_eret();

      // double fault: exception beats simultaneous eret
      start_trap(19'h00400, 19'h7FFF0);
      to_handler();
      bus.exception = 1'b1;
      bus.eret      = 1'b1;
      tick();
      bus.exception = 1'b0;
      bus.eret      = 1'b0;
      chk("dbl_halted", 32'(bus.halted), 1);
      chk("dbl_cause",  32'(bus.cause), 3);
      chk("dbl_flush",  32'(bus.flush), 1);
      chk("dbl_redir",  32'(bus.pc_redirect), 0);
      bus.eret = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      bus.eret = 1'b0;
      chk("dbl_hold_halted", 32'(bus.halted), 1);
      chk("dbl_hold_flush",  32'(bus.flush), 1);
      chk("dbl_hold_redir",  32'(bus.pc_redirect), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("dbl_rst_halted", 32'(bus.halted), 0);
      chk("dbl_rst_flush",  32'(bus.flush), 0);
      chk("dbl_rst_state",  32'(bus.state), 32'(S_IDLE));

`ifdef TRAP_COUNT_EN
      chk("cnt_rst", 32'(bus.trap_count), 0);
      for (int i = 0; i < 3; i++) begin
         start_trap(19'h00010, 19'h7FFF1);
         to_handler();
         do_eret();
      end
      chk("cnt_three", 32'(bus.trap_count), 3);
      bus.count_clr = 1'b1;
      start_trap(19'h00020, 19'h7FFF0);
      bus.count_clr = 1'b0;
      chk("cnt_clr_inc", 32'(bus.trap_count), 0);
      to_handler();
      do_eret();
      sat_inc = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      sat_inc = 1'b0;
      chk("cnt_sat", 32'(sat_count), 3);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      chk("cnt_sat_clr", 32'(sat_count), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
